// File: rtl/fila_de_instrucoes_param.sv
// -----------------------------------------------------------------------------
// fila_de_instrucoes_param
//
// Parametrised instruction queue between instruction fetch and dispatch.
// Holds up to DEPTH instructions of WIDTH bits in program order and presents
// the head first-word-fall-through. Supports:
//   - simultaneous push and pop, including while full
//   - a synchronous flush for branch mispredict recovery
//   - an occupancy count and an almost-full flag
//   - sticky overflow and underflow error flags
//
// Parameters:
//   WIDTH     - instruction word width in bits
//   DEPTH     - number of entries (power of two, >= 2)
//   AF_MARGIN - Almost_Full when Count >= DEPTH - AF_MARGIN (0 .. DEPTH-1)
//
// Ports:
//   Clock                in   single clock, rising edge
//   Reset                in   asynchronous, active-low reset
//   Push                 in   enqueue Din at this edge
//   Din                  in   instruction to enqueue
//   Pop                  in   consume the current head at this edge
//   Flush                in   discard all entries at this edge
//   Clear_Err            in   clear Overflow and Underflow at this edge
//   Instrucao_Despachada out  current head entry, 0 when empty
//   Full                 out  Count == DEPTH
//   Empty                out  Count == 0
//   Almost_Full          out  Count >= DEPTH - AF_MARGIN
//   Count                out  number of valid entries
//   Overflow             out  sticky: a push was dropped
//   Underflow            out  sticky: a pop was issued while empty
// -----------------------------------------------------------------------------
module fila_de_instrucoes_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       Pop,
    input  logic                       Flush,
    input  logic                       Clear_Err,
    output logic [WIDTH-1:0]           Instrucao_Despachada,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Almost_Full,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);

    // Storage is deliberately not reset; the head output is masked while empty.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic pushAccept;
    logic pushReject;
    logic popAccept;
    logic popReject;
    logic memWe;

    // Status flags depend only on the registered count, so no input reaches
    // an output combinationally.
    assign Full        = (count_q == CNT_FULL);
    assign Empty       = (count_q == '0);
    assign Almost_Full = (count_q >= CNT_AF);
    assign Count       = count_q;
    assign Overflow    = overflow_q;
    assign Underflow   = underflow_q;

    assign Instrucao_Despachada = Empty ? '0 : mem_q[rdPtr_q];

    // Classify this edge's requests. A push at full is still accepted when a
    // pop frees the head slot in the same edge. There is no bypass when
    // empty: the pop is rejected even if a push arrives alongside it.
    always_comb begin
        pushAccept = 1'b0;
        pushReject = 1'b0;
        popAccept  = 1'b0;
        popReject  = 1'b0;
        if (!Flush) begin
            pushAccept = Push && (!Full || Pop);
            pushReject = Push && Full && !Pop;
            popAccept  = Pop && !Empty;
            popReject  = Pop && Empty;
        end
    end

    // The write is gated by Reset so that a push seen while in reset never
    // lands in storage.
    assign memWe = pushAccept && Reset;

    // Next-state for pointers, count and sticky flags. Flush returns the
    // pointers and count to zero but leaves the error flags alone; for the
    // flags, a new error on the same edge as Clear_Err takes precedence.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = Clear_Err ? 1'b0 : overflow_q;
        underflow_d = Clear_Err ? 1'b0 : underflow_q;

        if (Flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushAccept) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (popAccept) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({pushAccept, popAccept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        if (pushReject) begin
            overflow_d = 1'b1;
        end
        if (popReject) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Circular buffer storage, written at the write pointer.
    always_ff @(posedge Clock) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= Din;
        end
    end

endmodule

// File: tb/tb_fila_de_instrucoes_param.sv
// -----------------------------------------------------------------------------
// tb_fila_de_instrucoes_param
//
// Directed testbench for fila_de_instrucoes_param with WIDTH=16, DEPTH=4,
// AF_MARGIN=1. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_fila_de_instrucoes_param;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 1;

    logic              Clock;
    logic              Reset;
    logic              Push;
    logic [WIDTH-1:0]  Din;
    logic              Pop;
    logic              Flush;
    logic              Clear_Err;
    logic [WIDTH-1:0]  Instrucao_Despachada;
    logic              Full;
    logic              Empty;
    logic              Almost_Full;
    logic [2:0]        Count;
    logic              Overflow;
    logic              Underflow;

    int asserts;
    int failures;

    fila_de_instrucoes_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .Clock                (Clock),
        .Reset                (Reset),
        .Push                 (Push),
        .Din                  (Din),
        .Pop                  (Pop),
        .Flush                (Flush),
        .Clear_Err            (Clear_Err),
        .Instrucao_Despachada (Instrucao_Despachada),
        .Full                 (Full),
        .Empty                (Empty),
        .Almost_Full          (Almost_Full),
        .Count                (Count),
        .Overflow             (Overflow),
        .Underflow            (Underflow)
    );

    // Free-running clock, period 10.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance one rising edge and settle 1 unit past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Push      = 1'b0;
        Pop       = 1'b0;
        Flush     = 1'b0;
        Clear_Err = 1'b0;
        Din       = '0;
    endtask

    // Compare full status snapshot against expected values.
    task automatic check_status(input string name, input logic [2:0] expCount,
                                input logic expEmpty, input logic expFull,
                                input logic expAf, input logic [15:0] expHead);
        asserts++;
        if (Count !== expCount) begin
            failures++;
            $display("[TB] FAIL %s count: got %0d expected %0d", name, Count, expCount);
        end
        asserts++;
        if (Empty !== expEmpty) begin
            failures++;
            $display("[TB] FAIL %s empty: got %b expected %b", name, Empty, expEmpty);
        end
        asserts++;
        if (Full !== expFull) begin
            failures++;
            $display("[TB] FAIL %s full: got %b expected %b", name, Full, expFull);
        end
        asserts++;
        if (Almost_Full !== expAf) begin
            failures++;
            $display("[TB] FAIL %s almost_full: got %b expected %b", name, Almost_Full, expAf);
        end
        asserts++;
        if (Instrucao_Despachada !== expHead) begin
            failures++;
            $display("[TB] FAIL %s head: got %h expected %h", name, Instrucao_Despachada, expHead);
        end
    endtask

    task automatic check_flags(input string name, input logic expOvf, input logic expUnf);
        asserts++;
        if (Overflow !== expOvf) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %b expected %b", name, Overflow, expOvf);
        end
        asserts++;
        if (Underflow !== expUnf) begin
            failures++;
            $display("[TB] FAIL %s underflow: got %b expected %b", name, Underflow, expUnf);
        end
    endtask

    // Reset held for two edges with Push active must leave the queue empty.
    task automatic test_reset();
        idle_inputs();
        Reset = 1'b0;
        Push  = 1'b1;
        Din   = 16'hBEEF;
        tick();
        tick();
        check_status("reset", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_flags("reset", 1'b0, 1'b0);
        idle_inputs();
        Reset = 1'b1;
        tick();
        check_status("reset_release", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    // Fill to full in order, then drain checking program order.
    task automatic test_fill_and_order();
        logic [15:0] words [4];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            Push = 1'b1;
            Din  = words[i];
            tick();
            check_status($sformatf("fill%0d", i), 3'(i + 1), 1'b0, (i == 3),
                         (i >= 2), 16'h1111);
        end
        Push = 1'b0;
        Din  = '0;
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (Instrucao_Despachada !== words[i]) begin
                failures++;
                $display("[TB] FAIL drain%0d head: got %h expected %h", i,
                         Instrucao_Despachada, words[i]);
            end
            Pop = 1'b1;
            tick();
        end
        Pop = 1'b0;
        check_status("drained", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_flags("drained", 1'b0, 1'b0);
    endtask

    // Overflow at full, then push+pop at full across pointer wrap-around.
    task automatic test_full_push_wrap();
        logic [15:0] fillWords [4];
        logic [15:0] pushWords [3];
        logic [15:0] headAfter [3];
        logic [15:0] drainWords [4];
        fillWords[0] = 16'h1111;
        fillWords[1] = 16'h2222;
        fillWords[2] = 16'h3333;
        fillWords[3] = 16'h4444;
        pushWords[0] = 16'h7001;
        pushWords[1] = 16'h7002;
        pushWords[2] = 16'h7003;
        headAfter[0] = 16'h3333;
        headAfter[1] = 16'h4444;
        headAfter[2] = 16'h6666;
        drainWords[0] = 16'h6666;
        drainWords[1] = 16'h7001;
        drainWords[2] = 16'h7002;
        drainWords[3] = 16'h7003;

        for (int i = 0; i < 4; i++) begin
            Push = 1'b1;
            Din  = fillWords[i];
            tick();
        end
        Din = 16'h5555;
        tick();
        check_status("overflow_push", 3'd4, 1'b0, 1'b1, 1'b1, 16'h1111);
        check_flags("overflow_push", 1'b1, 1'b0);

        Din = 16'h6666;
        Pop = 1'b1;
        tick();
        check_status("push_pop_full", 3'd4, 1'b0, 1'b1, 1'b1, 16'h2222);

        for (int i = 0; i < 3; i++) begin
            Din = pushWords[i];
            tick();
            check_status($sformatf("wrap%0d", i), 3'd4, 1'b0, 1'b1, 1'b1, headAfter[i]);
        end

        Push = 1'b0;
        Din  = '0;
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (Instrucao_Despachada !== drainWords[i]) begin
                failures++;
                $display("[TB] FAIL wrap_drain%0d head: got %h expected %h", i,
                         Instrucao_Despachada, drainWords[i]);
            end
            tick();
        end
        Pop = 1'b0;
        check_status("wrap_drained", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_flags("wrap_drained", 1'b1, 1'b0);
    endtask

    // Pop on empty with a simultaneous push: push lands, pop flagged.
    task automatic test_empty_pop();
        Push = 1'b1;
        Pop  = 1'b1;
        Din  = 16'hAAAA;
        tick();
        idle_inputs();
        check_status("empty_pop", 3'd1, 1'b0, 1'b0, 1'b0, 16'hAAAA);
        check_flags("empty_pop", 1'b1, 1'b1);

        Clear_Err = 1'b1;
        tick();
        Clear_Err = 1'b0;
        check_flags("clear_err", 1'b0, 1'b0);
        check_status("clear_err", 3'd1, 1'b0, 1'b0, 1'b0, 16'hAAAA);

        // Clear_Err together with a fresh error: set wins.
        Pop = 1'b1;
        tick();
        Pop       = 1'b1;
        Clear_Err = 1'b1;
        tick();
        idle_inputs();
        check_flags("clear_vs_set", 1'b0, 1'b1);
    endtask

    // Flush with push and pop active discards everything, keeps flags.
    task automatic test_flush();
        Push = 1'b1;
        Din  = 16'hB001;
        tick();
        Din = 16'hB002;
        tick();
        Din = 16'hB003;
        tick();
        check_status("pre_flush", 3'd3, 1'b0, 1'b0, 1'b1, 16'hB001);

        Din   = 16'hB004;
        Pop   = 1'b1;
        Flush = 1'b1;
        tick();
        idle_inputs();
        check_status("flush", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_flags("flush", 1'b0, 1'b1);

        Push = 1'b1;
        Din  = 16'h7777;
        tick();
        idle_inputs();
        check_status("post_flush", 3'd1, 1'b0, 1'b0, 1'b0, 16'h7777);
    endtask

    // Asynchronous reset asserted between edges clears outputs immediately.
    task automatic test_async_reset();
        Push = 1'b1;
        Din  = 16'h8888;
        tick();
        idle_inputs();
        check_status("pre_async", 3'd2, 1'b0, 1'b0, 1'b0, 16'h7777);

        #2;
        Reset = 1'b0;
        #1;
        check_status("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_flags("async_reset", 1'b0, 1'b0);

        Push = 1'b1;
        Din  = 16'h9999;
        tick();
        check_status("reset_held_push", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        idle_inputs();
        Reset = 1'b1;
        tick();
        check_status("async_release", 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        Reset    = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_fill_and_order();
        test_full_push_wrap();
        test_empty_pop();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
